// File: rtl/axi4_sram_slave_pkg.sv
// Shared widths, protocol constants and FSM encodings for the AXI4 SRAM slave.
// The AXI4 widths match the noc_axi4_bridge master port this slave terminates.
package axi4_sram_slave_pkg;

  localparam int AXI4_ID_WIDTH     = 6;
  localparam int AXI4_ADDR_WIDTH   = 64;
  localparam int AXI4_DATA_WIDTH   = 512;
  localparam int AXI4_STRB_WIDTH   = AXI4_DATA_WIDTH / 8;
  localparam int AXI4_LEN_WIDTH    = 8;
  localparam int AXI4_SIZE_WIDTH   = 3;
  localparam int AXI4_BURST_WIDTH  = 2;
  localparam int AXI4_LOCK_WIDTH   = 1;
  localparam int AXI4_CACHE_WIDTH  = 4;
  localparam int AXI4_PROT_WIDTH   = 3;
  localparam int AXI4_QOS_WIDTH    = 4;
  localparam int AXI4_REGION_WIDTH = 4;
  localparam int AXI4_USER_WIDTH   = 11;
  localparam int AXI4_RESP_WIDTH   = 2;

  localparam logic [1:0] AXI4_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI4_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI4_RESP_SLVERR = 2'b10;

  localparam logic [1:0] AXI4_SRAM_W_IDLE = 2'd0;
  localparam logic [1:0] AXI4_SRAM_W_DATA = 2'd1;
  localparam logic [1:0] AXI4_SRAM_W_RESP = 2'd2;

  localparam logic [1:0] AXI4_SRAM_R_IDLE  = 2'd0;
  localparam logic [1:0] AXI4_SRAM_R_FETCH = 2'd1;
  localparam logic [1:0] AXI4_SRAM_R_DATA  = 2'd2;

  // Only full-width INCR bursts are served; anything else gets SLVERR.
  function automatic logic burst_legal(input logic [AXI4_BURST_WIDTH-1:0] burst,
                                       input logic [AXI4_SIZE_WIDTH-1:0]  size,
                                       input logic [AXI4_SIZE_WIDTH-1:0]  beat_size);
    return (burst == AXI4_BURST_INCR) && (size == beat_size);
  endfunction

endpackage

// File: rtl/axi4_sram_slave_mem.sv
// Simple dual-port line array: byte-enabled synchronous write, registered read.
// A same-cycle write and read of one line returns the pre-write contents.
module axi4_sram_slave_mem #(
  parameter int DEPTH_LOG2 = 10,
  parameter int DATA_W     = 512
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr_en,
  input  logic [DEPTH_LOG2-1:0] i_wr_idx,
  input  logic [DATA_W-1:0]     i_wr_data,
  input  logic [DATA_W/8-1:0]   i_wr_strb,
  input  logic                  i_rd_en,
  input  logic                  i_rd_zero,
  input  logic [DEPTH_LOG2-1:0] i_rd_idx,
  output logic [DATA_W-1:0]     o_rd_data
);

  logic [DATA_W-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];
  logic [DATA_W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (i_wr_strb[b]) r_mem[i_wr_idx][b*8 +: 8] <= i_wr_data[b*8 +: 8];
      end
    end
  end

  // The read register is reset so rdata is defined before the first fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= i_rd_zero ? '0 : r_mem[i_rd_idx];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/axi4_sram_slave.sv
// AXI4 slave memory behind noc_axi4_bridge: independent write and read FSMs
// serving full-width INCR bursts out of a byte-enabled line array.
module axi4_sram_slave
  import axi4_sram_slave_pkg::*;
#(
  parameter int MEM_DEPTH_LOG2 = 10,
  parameter int BEAT_SIZE      = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [AXI4_ID_WIDTH-1:0]     s_axi_awid,
  input  logic [AXI4_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [AXI4_LEN_WIDTH-1:0]    s_axi_awlen,
  input  logic [AXI4_SIZE_WIDTH-1:0]   s_axi_awsize,
  input  logic [AXI4_BURST_WIDTH-1:0]  s_axi_awburst,
  input  logic [AXI4_LOCK_WIDTH-1:0]   s_axi_awlock,
  input  logic [AXI4_CACHE_WIDTH-1:0]  s_axi_awcache,
  input  logic [AXI4_PROT_WIDTH-1:0]   s_axi_awprot,
  input  logic [AXI4_QOS_WIDTH-1:0]    s_axi_awqos,
  input  logic [AXI4_REGION_WIDTH-1:0] s_axi_awregion,
  input  logic [AXI4_USER_WIDTH-1:0]   s_axi_awuser,
  input  logic                         s_axi_awvalid,
  output logic                         s_axi_awready,
  input  logic [AXI4_ID_WIDTH-1:0]     s_axi_wid,
  input  logic [AXI4_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [AXI4_STRB_WIDTH-1:0]   s_axi_wstrb,
  input  logic                         s_axi_wlast,
  input  logic [AXI4_USER_WIDTH-1:0]   s_axi_wuser,
  input  logic                         s_axi_wvalid,
  output logic                         s_axi_wready,
  output logic [AXI4_ID_WIDTH-1:0]     s_axi_bid,
  output logic [AXI4_RESP_WIDTH-1:0]   s_axi_bresp,
  output logic [AXI4_USER_WIDTH-1:0]   s_axi_buser,
  output logic                         s_axi_bvalid,
  input  logic                         s_axi_bready,
  input  logic [AXI4_ID_WIDTH-1:0]     s_axi_arid,
  input  logic [AXI4_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [AXI4_LEN_WIDTH-1:0]    s_axi_arlen,
  input  logic [AXI4_SIZE_WIDTH-1:0]   s_axi_arsize,
  input  logic [AXI4_BURST_WIDTH-1:0]  s_axi_arburst,
  input  logic [AXI4_LOCK_WIDTH-1:0]   s_axi_arlock,
  input  logic [AXI4_CACHE_WIDTH-1:0]  s_axi_arcache,
  input  logic [AXI4_PROT_WIDTH-1:0]   s_axi_arprot,
  input  logic [AXI4_QOS_WIDTH-1:0]    s_axi_arqos,
  input  logic [AXI4_REGION_WIDTH-1:0] s_axi_arregion,
  input  logic [AXI4_USER_WIDTH-1:0]   s_axi_aruser,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  output logic [AXI4_ID_WIDTH-1:0]     s_axi_rid,
  output logic [AXI4_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [AXI4_RESP_WIDTH-1:0]   s_axi_rresp,
  output logic                         s_axi_rlast,
  output logic [AXI4_USER_WIDTH-1:0]   s_axi_ruser,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  output logic [1:0]                   o_dbg_wstate,
  output logic [1:0]                   o_dbg_rstate
);

  localparam int IDX_HI = BEAT_SIZE + MEM_DEPTH_LOG2 - 1;
  localparam logic [AXI4_SIZE_WIDTH-1:0] BEAT_SIZE_C = AXI4_SIZE_WIDTH'(BEAT_SIZE);

  // Handshake rule on every channel: a transfer happens on a rising clk edge
  // where valid and ready are both 1; valid and payload hold until then.
  logic                        r_init_done;
  logic [1:0]                  r_wstate, r_rstate;
  logic [AXI4_ID_WIDTH-1:0]    r_bid, r_rid;
  logic [AXI4_RESP_WIDTH-1:0]  r_bresp, r_rresp;
  logic [MEM_DEPTH_LOG2-1:0]   r_widx, r_ridx;
  logic [AXI4_LEN_WIDTH-1:0]   r_wlen, r_wcnt, r_rlen, r_rcnt;
  logic                        r_wlegal, r_rlegal;
  logic                        w_aw_hs, w_w_hs, w_ar_hs, w_r_hs, w_aw_legal, w_ar_legal;
  logic                        w_unused;

  assign s_axi_awready = r_init_done && (r_wstate == AXI4_SRAM_W_IDLE);
  assign s_axi_wready  = (r_wstate == AXI4_SRAM_W_DATA);
  assign s_axi_bvalid  = (r_wstate == AXI4_SRAM_W_RESP);
  assign s_axi_bid     = r_bid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_buser   = '0;
  assign s_axi_arready = r_init_done && (r_rstate == AXI4_SRAM_R_IDLE);
  assign s_axi_rvalid  = (r_rstate == AXI4_SRAM_R_DATA);
  assign s_axi_rid     = r_rid;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rlast   = s_axi_rvalid && (r_rcnt == r_rlen);
  assign s_axi_ruser   = '0;
  assign o_dbg_wstate  = r_wstate;
  assign o_dbg_rstate  = r_rstate;

  assign w_aw_hs    = s_axi_awvalid && s_axi_awready;
  assign w_w_hs     = s_axi_wvalid && s_axi_wready;
  assign w_ar_hs    = s_axi_arvalid && s_axi_arready;
  assign w_r_hs     = s_axi_rvalid && s_axi_rready;
  assign w_aw_legal = burst_legal(s_axi_awburst, s_axi_awsize, BEAT_SIZE_C);
  assign w_ar_legal = burst_legal(s_axi_arburst, s_axi_arsize, BEAT_SIZE_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_init_done <= 1'b0;
    else        r_init_done <= 1'b1;
  end

  // Write side: the beat count, not wlast, decides where the burst ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wstate <= AXI4_SRAM_W_IDLE;
      r_bid    <= '0;
      r_bresp  <= '0;
      r_widx   <= '0;
      r_wlen   <= '0;
      r_wcnt   <= '0;
      r_wlegal <= 1'b0;
    end else begin
      case (r_wstate)
        AXI4_SRAM_W_IDLE: if (w_aw_hs) begin
          r_bid    <= s_axi_awid;
          r_widx   <= s_axi_awaddr[IDX_HI:BEAT_SIZE];
          r_wlen   <= s_axi_awlen;
          r_wcnt   <= '0;
          r_wlegal <= w_aw_legal;
          r_bresp  <= w_aw_legal ? AXI4_RESP_OKAY : AXI4_RESP_SLVERR;
          r_wstate <= AXI4_SRAM_W_DATA;
        end
        AXI4_SRAM_W_DATA: if (w_w_hs) begin
          r_widx <= r_widx + 1'b1;
          r_wcnt <= r_wcnt + 1'b1;
          if (r_wcnt == r_wlen) r_wstate <= AXI4_SRAM_W_RESP;
        end
        AXI4_SRAM_W_RESP: if (s_axi_bready) r_wstate <= AXI4_SRAM_W_IDLE;
        default: r_wstate <= AXI4_SRAM_W_IDLE;
      endcase
    end
  end

  // Read side: one fetch cycle per beat, so beats stream at half rate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rstate <= AXI4_SRAM_R_IDLE;
      r_rid    <= '0;
      r_rresp  <= '0;
      r_ridx   <= '0;
      r_rlen   <= '0;
      r_rcnt   <= '0;
      r_rlegal <= 1'b0;
    end else begin
      case (r_rstate)
        AXI4_SRAM_R_IDLE: if (w_ar_hs) begin
          r_rid    <= s_axi_arid;
          r_ridx   <= s_axi_araddr[IDX_HI:BEAT_SIZE];
          r_rlen   <= s_axi_arlen;
          r_rcnt   <= '0;
          r_rlegal <= w_ar_legal;
          r_rresp  <= w_ar_legal ? AXI4_RESP_OKAY : AXI4_RESP_SLVERR;
          r_rstate <= AXI4_SRAM_R_FETCH;
        end
        AXI4_SRAM_R_FETCH: r_rstate <= AXI4_SRAM_R_DATA;
        AXI4_SRAM_R_DATA: if (w_r_hs) begin
          if (s_axi_rlast) begin
            r_rstate <= AXI4_SRAM_R_IDLE;
          end else begin
            r_ridx   <= r_ridx + 1'b1;
            r_rcnt   <= r_rcnt + 1'b1;
            r_rstate <= AXI4_SRAM_R_FETCH;
          end
        end
        default: r_rstate <= AXI4_SRAM_R_IDLE;
      endcase
    end
  end

  axi4_sram_slave_mem #(
    .DEPTH_LOG2 (MEM_DEPTH_LOG2),
    .DATA_W     (AXI4_DATA_WIDTH)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_w_hs && r_wlegal),
    .i_wr_idx  (r_widx),
    .i_wr_data (s_axi_wdata),
    .i_wr_strb (s_axi_wstrb),
    .i_rd_en   (r_rstate == AXI4_SRAM_R_FETCH),
    .i_rd_zero (!r_rlegal),
    .i_rd_idx  (r_ridx),
    .o_rd_data (s_axi_rdata)
  );

  // Sideband fields and alias/offset address bits carry no meaning here.
  assign w_unused = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awregion,
                      s_axi_awuser, s_axi_awaddr[AXI4_ADDR_WIDTH-1:IDX_HI+1],
                      s_axi_awaddr[BEAT_SIZE-1:0], s_axi_wid, s_axi_wlast, s_axi_wuser,
                      s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arregion,
                      s_axi_aruser, s_axi_araddr[AXI4_ADDR_WIDTH-1:IDX_HI+1],
                      s_axi_araddr[BEAT_SIZE-1:0]};

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Directed bench for axi4_sram_slave: a table of single-beat write/read vectors
// plus hand-written burst, wrap, backpressure, concurrency and reset sequences.
module tb_axi4_sram_slave;
  import axi4_sram_slave_pkg::*;

  localparam int DW = AXI4_DATA_WIDTH;
  localparam int SW = AXI4_STRB_WIDTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AXI4_ID_WIDTH-1:0]     awid, wid, bid, arid, rid;
  logic [AXI4_ADDR_WIDTH-1:0]   awaddr, araddr;
  logic [AXI4_LEN_WIDTH-1:0]    awlen, arlen;
  logic [AXI4_SIZE_WIDTH-1:0]   awsize, arsize;
  logic [AXI4_BURST_WIDTH-1:0]  awburst, arburst;
  logic [AXI4_LOCK_WIDTH-1:0]   awlock, arlock;
  logic [AXI4_CACHE_WIDTH-1:0]  awcache, arcache;
  logic [AXI4_PROT_WIDTH-1:0]   awprot, arprot;
  logic [AXI4_QOS_WIDTH-1:0]    awqos, arqos;
  logic [AXI4_REGION_WIDTH-1:0] awregion, arregion;
  logic [AXI4_USER_WIDTH-1:0]   awuser, wuser, buser, aruser, ruser;
  logic [DW-1:0]                wdata, rdata;
  logic [SW-1:0]                wstrb;
  logic [1:0]                   bresp, rresp, dbg_w, dbg_r;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready;

  axi4_sram_slave dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awlock(awlock), .s_axi_awcache(awcache),
    .s_axi_awprot(awprot), .s_axi_awqos(awqos), .s_axi_awregion(awregion),
    .s_axi_awuser(awuser), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wid(wid), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wuser(wuser), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_buser(buser), .s_axi_bvalid(bvalid),
    .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arlock(arlock), .s_axi_arcache(arcache),
    .s_axi_arprot(arprot), .s_axi_arqos(arqos), .s_axi_arregion(arregion),
    .s_axi_aruser(aruser), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_ruser(ruser), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .o_dbg_wstate(dbg_w), .o_dbg_rstate(dbg_r)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] wbeat[16];
  logic [SW-1:0] all_strb;

  typedef struct {
    logic [5:0]    id;
    logic [63:0]   waddr;
    logic [7:0]    wlen;
    logic [2:0]    wsize;
    logic [1:0]    wburst;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic [1:0]    exp_bresp;
    logic [63:0]   raddr;
    logic [2:0]    rsize;
    logic [1:0]    rburst;
    logic [DW-1:0] exp_rdata;
    logic [1:0]    exp_rresp;
  } vec_t;
  vec_t vt[6];

  function automatic logic [DW-1:0] pat(input logic [7:0] base);
    logic [DW-1:0] v;
    for (int i = 0; i < DW/8; i++) v[i*8 +: 8] = base + 8'(i);
    return v;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_awready"}, awready, 0);
    check({tag, "_wready"}, wready, 0);
    check({tag, "_bvalid"}, bvalid, 0);
    check({tag, "_arready"}, arready, 0);
    check({tag, "_rvalid"}, rvalid, 0);
    check({tag, "_rlast"}, rlast, 0);
    check({tag, "_bid"}, bid, 0);
    check({tag, "_bresp"}, bresp, 0);
    check({tag, "_rid"}, rid, 0);
    check({tag, "_rresp"}, rresp, 0);
    check({tag, "_rdata"}, rdata, 0);
  endtask

  task automatic ar_send(input logic [5:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int k = 0;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    while (!arready && k < 20) begin tick(); k++; end
    check("ar_accept", arready, 1);
    tick();
    arvalid = 1'b0;
  endtask

  // Sends nbeats beats from wbeat[]; collects B only when do_resp is set.
  task automatic write_burst(input logic [5:0] id, input logic [63:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input logic [SW-1:0] strb,
                             input int nbeats, input bit do_resp, input logic [1:0] exp_bresp);
    int k = 0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    while (!awready && k < 20) begin tick(); k++; end
    check("aw_accept", awready, 1);
    tick();
    awvalid = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      wdata = wbeat[b]; wstrb = strb; wlast = (b == int'(len)); wvalid = 1'b1;
      k = 0;
      while (!wready && k < 10) begin tick(); k++; end
      check("w_ready_wait", k, 0);
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    if (do_resp) begin
      k = 0;
      while (!bvalid && k < 10) begin tick(); k++; end
      check("b_latency", k, 0);
      check("bid", bid, id);
      check("bresp", bresp, exp_bresp);
      bready = 1'b1;
      tick();
      bready = 1'b0;
    end
  endtask

  task automatic read_burst(input logic [5:0] id, input logic [63:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic [1:0] exp_rresp);
    int k;
    logic [DW-1:0] exp_d;
    ar_send(id, addr, len, size, burst);
    for (int b = 0; b <= int'(len); b++) begin
      k = 0;
      while (!rvalid && k < 10) begin tick(); k++; end
      check("r_latency", k, 1);
      if (exp_q.size() == 0) begin
        check("r_exp_queue_empty", 1, 0);
        exp_d = '0;
      end else begin
        exp_d = exp_q.pop_front();
      end
      check("rdata", rdata, exp_d);
      check("rid", rid, id);
      check("rresp", rresp, exp_rresp);
      check("rlast", rlast, (b == int'(len)));
      rready = 1'b1;
      tick();
      rready = 1'b0;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: bench did not finish within the time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] ones, ones_b0, e3;
    logic [SW-1:0] top_strb;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awlock = '0; awcache = '0;
    awprot = '0; awqos = '0; awregion = '0; awuser = '0; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wuser = '0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arlock = '0; arcache = '0;
    arprot = '0; arqos = '0; arregion = '0; aruser = '0; arvalid = 1'b0; rready = 1'b0;

    all_strb = '1;
    ones     = '1;
    ones_b0  = {{(DW-8){1'b1}}, 8'h00};
    e3       = ones_b0;
    e3[DW-1 -: 8] = 8'h50;
    top_strb = '0;
    top_strb[SW-1] = 1'b1;

    vt[0] = '{6'd3, 64'h40,    8'd0, 3'd6, 2'b01, pat(8'hA5), all_strb, 2'b00, 64'h40, 3'd6, 2'b01, pat(8'hA5), 2'b00};
    vt[1] = '{6'd4, 64'h80,    8'd0, 3'd6, 2'b01, ones,       all_strb, 2'b00, 64'h80, 3'd6, 2'b01, ones,       2'b00};
    vt[2] = '{6'd5, 64'h80,    8'd0, 3'd6, 2'b01, '0,         64'h1,    2'b00, 64'h80, 3'd6, 2'b01, ones_b0,    2'b00};
    vt[3] = '{6'd6, 64'h10085, 8'd0, 3'd6, 2'b01, pat(8'h11), top_strb, 2'b00, 64'h80, 3'd6, 2'b01, e3,         2'b00};
    vt[4] = '{6'd7, 64'h40,    8'd1, 3'd6, 2'b00, '0,         all_strb, 2'b10, 64'h40, 3'd6, 2'b01, pat(8'hA5), 2'b00};
    vt[5] = '{6'd8, 64'hC0,    8'd0, 3'd6, 2'b01, pat(8'h33), all_strb, 2'b00, 64'hC0, 3'd3, 2'b01, '0,         2'b10};

    repeat (2) tick();
    reset_check("reset");
    rst_n = 1'b1;
    check("awready_before_init", awready, 0);
    tick();
    check("awready_after_init", awready, 1);
    check("arready_after_init", arready, 1);

    for (int i = 0; i < 6; i++) begin
      for (int b = 0; b < 16; b++) wbeat[b] = vt[i].wdata;
      write_burst(vt[i].id, vt[i].waddr, vt[i].wlen, vt[i].wsize, vt[i].wburst, vt[i].wstrb,
                  int'(vt[i].wlen) + 1, 1'b1, vt[i].exp_bresp);
      exp_q.push_back(vt[i].exp_rdata);
      read_burst(vt[i].id + 6'd1, vt[i].raddr, 8'd0, vt[i].rsize, vt[i].rburst, vt[i].exp_rresp);
    end

    // 4-beat burst starting at index 1022 wraps to indices 0 and 1.
    wbeat[0] = pat(8'h10); wbeat[1] = pat(8'h20); wbeat[2] = pat(8'h30); wbeat[3] = pat(8'h40);
    write_burst(6'd9, 64'hFF80, 8'd3, 3'd6, 2'b01, all_strb, 4, 1'b1, 2'b00);
    for (int b = 0; b < 4; b++) exp_q.push_back(wbeat[b]);
    read_burst(6'd10, 64'hFF80, 8'd3, 3'd6, 2'b01, 2'b00);
    exp_q.push_back(pat(8'h30));
    read_burst(6'd10, 64'h0, 8'd0, 3'd6, 2'b01, 2'b00);
    exp_q.push_back(pat(8'h40));
    read_burst(6'd10, 64'h40, 8'd0, 3'd6, 2'b01, 2'b00);

    // Backpressure: B and R both held for 10 cycles.
    wbeat[0] = pat(8'h60);
    write_burst(6'd11, 64'h200, 8'd0, 3'd6, 2'b01, all_strb, 1, 1'b0, 2'b00);
    ar_send(6'd12, 64'h200, 8'd0, 3'd6, 2'b01);
    tick();
    for (int c = 0; c < 10; c++) begin
      check("bp_bvalid", bvalid, 1);
      check("bp_bid", bid, 11);
      check("bp_bresp", bresp, 0);
      check("bp_rvalid", rvalid, 1);
      check("bp_rid", rid, 12);
      check("bp_rdata", rdata, pat(8'h60));
      check("bp_rlast", rlast, 1);
      check("bp_rresp", rresp, 0);
      tick();
    end
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    check("bp_bvalid_done", bvalid, 0);
    check("bp_rvalid_done", rvalid, 0);
    check("bp_awready_next", awready, 1);
    check("bp_arready_next", arready, 1);

    // Same-cycle write beat and fetch to one index return the old line.
    wbeat[0] = pat(8'h70);
    write_burst(6'd13, 64'h240, 8'd0, 3'd6, 2'b01, all_strb, 1, 1'b1, 2'b00);
    awid = 6'd14; awaddr = 64'h240; awlen = 8'd0; awsize = 3'd6; awburst = 2'b01; awvalid = 1'b1;
    arid = 6'd15; araddr = 64'h240; arlen = 8'd0; arsize = 3'd6; arburst = 2'b01; arvalid = 1'b1;
    wdata = pat(8'h80); wstrb = all_strb; wlast = 1'b1; wvalid = 1'b1;
    check("conc_awready", awready, 1);
    check("conc_arready", arready, 1);
    tick();
    awvalid = 1'b0; arvalid = 1'b0;
    check("conc_wready", wready, 1);
    tick();
    wvalid = 1'b0; wlast = 1'b0;
    check("conc_bvalid", bvalid, 1);
    check("conc_rvalid", rvalid, 1);
    check("conc_old_data", rdata, pat(8'h70));
    check("conc_rid", rid, 15);
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    exp_q.push_back(pat(8'h80));
    read_burst(6'd16, 64'h240, 8'd0, 3'd6, 2'b01, 2'b00);

    // Reset after two beats of a four-beat write.
    wbeat[0] = pat(8'h90); wbeat[1] = pat(8'hA0); wbeat[2] = pat(8'hB0); wbeat[3] = pat(8'hC0);
    write_burst(6'd17, 64'h400, 8'd3, 3'd6, 2'b01, all_strb, 2, 1'b0, 2'b00);
    rst_n = 1'b0;
    #1;
    reset_check("midrst");
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst_awready", awready, 1);
    exp_q.push_back(pat(8'h90));
    read_burst(6'd18, 64'h400, 8'd0, 3'd6, 2'b01, 2'b00);
    exp_q.push_back(pat(8'hA0));
    read_burst(6'd19, 64'h440, 8'd0, 3'd6, 2'b01, 2'b00);
    check("buser_zero", buser, 0);
    check("ruser_zero", ruser, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
